// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encoding, operand width and the issue-entry layout
// used by alu_share_arbiter.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] SLL  = 4'd2;
  localparam logic [3:0] SLT  = 4'd3;
  localparam logic [3:0] SLTU = 4'd4;
  localparam logic [3:0] XOR  = 4'd5;
  localparam logic [3:0] SRL  = 4'd6;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] OR   = 4'd8;
  localparam logic [3:0] AND  = 4'd9;

  localparam logic [3:0] ALU_CTRL_MAX = 4'd9;

  typedef enum logic {
    OWNER_REQ0 = 1'b0,
    OWNER_REQ1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    owner_t          owner;
    logic            err;
  } issue_entry_t;

  function automatic logic ctrlIllegal(input logic [3:0] ctrl);
    return ctrl > ALU_CTRL_MAX;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input arbiter for alu_share_arbiter. Round-robin by default; defining
// ALU_ARB_FIXED_PRIO_EN gives req0 absolute priority and drops the last_grant state.
module rr_arb2 (
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic elig0,
  input  logic elig1,
  output logic grant0,
  output logic grant1
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  always_comb begin
    grant0 = elig0;
    grant1 = elig1 && !elig0;
  end

`else

  logic last_grant;

  // On contention the requester that did not win last time gets the slot.
  always_comb begin
    grant0 = elig0 && (!elig1 || last_grant);
    grant1 = elig1 && (!elig0 || !last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters through a one-cycle
// issue register and per-requester response slots. Option macro: ALU_ARB_FIXED_PRIO_EN.
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_ctrl,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp0_err,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_ctrl,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic            rsp1_err,

  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
);

  issue_entry_t issue;
  issue_entry_t new_entry;
  logic         issue_valid;
  logic         busy0, busy1;
  logic         elig0, elig1;
  logic         grant0, grant1;
  logic         drain0, drain1;
  logic [3:0]   sel_ctrl;
  logic [XLEN-1:0] sel_a, sel_b;
  logic         sel_illegal;

  // A requester stays blocked from grant until its response slot has been consumed.
  assign drain0 = issue_valid && (issue.owner == OWNER_REQ0);
  assign drain1 = issue_valid && (issue.owner == OWNER_REQ1);
  assign busy0  = drain0 || rsp0_valid;
  assign busy1  = drain1 || rsp1_valid;
  assign elig0  = req0_valid && !busy0 && !rst;
  assign elig1  = req1_valid && !busy1 && !rst;

  rr_arb2 u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .elig0  (elig0),
    .elig1  (elig1),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Illegal operations still occupy a slot, but run as a harmless ADD 0+0.
  always_comb begin
    sel_ctrl    = grant1 ? req1_ctrl : req0_ctrl;
    sel_a       = grant1 ? req1_a    : req0_a;
    sel_b       = grant1 ? req1_b    : req0_b;
    sel_illegal = ctrlIllegal(sel_ctrl);
    new_entry.ctrl  = sel_illegal ? ADD : sel_ctrl;
    new_entry.a     = sel_illegal ? '0  : sel_a;
    new_entry.b     = sel_illegal ? '0  : sel_b;
    new_entry.owner = grant1 ? OWNER_REQ1 : OWNER_REQ0;
    new_entry.err   = sel_illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue       <= '0;
    end else begin
      issue_valid <= grant0 || grant1;
      if (grant0 || grant1) begin
        issue <= new_entry;
      end
    end
  end

  assign alu_ctrl = issue_valid ? issue.ctrl : ADD;
  assign alu_a    = issue_valid ? issue.a    : '0;
  assign alu_b    = issue_valid ? issue.b    : '0;

  // The owner's slot is always empty at drain, so drain and consume never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      rsp1_err    <= 1'b0;
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (drain0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
        rsp0_zero   <= (alu_result == '0);
        rsp0_err    <= issue.err;
      end
      if (rsp1_valid && rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
      if (drain1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
        rsp1_zero   <= (alu_result == '0);
        rsp1_err    <= issue.err;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single operations plus
// hand-written contention, backpressure and reset sequences.
module tb_alu_share_arbiter;
  import alu_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk, rst;
  logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [3:0]      req0_ctrl, req1_ctrl, alu_ctrl;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;

  typedef struct {
    logic            who;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] expResult;
    logic            expZero;
    logic            expErr;
  } vec_t;

  vec_t vecs[12];
  int   vecCount  = 0;
  int   missCount = 0;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared combinational ALU.
  always_comb begin
    case (alu_ctrl)
      ADD:     alu_result = alu_a + alu_b;
      SUB:     alu_result = alu_a - alu_b;
      SLL:     alu_result = alu_a << alu_b[4:0];
      SLT:     alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      SLTU:    alu_result = {31'd0, alu_a < alu_b};
      XOR:     alu_result = alu_a ^ alu_b;
      SRL:     alu_result = alu_a >> alu_b[4:0];
      SRA:     alu_result = $signed(alu_a) >>> alu_b[4:0];
      OR:      alu_result = alu_a | alu_b;
      AND:     alu_result = alu_a & alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    req0_valid = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0; rsp0_ready = 1;
    req1_valid = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0; rsp1_ready = 1;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1;
    req0_valid = 1;
    req1_valid = 1;
    nextCycle();
    nextCycle();
    #1;
    checkOutput("reset req0_ready", req0_ready, 0);
    checkOutput("reset req1_ready", req1_ready, 0);
    checkOutput("reset rsp0_valid", rsp0_valid, 0);
    checkOutput("reset rsp1_valid", rsp1_valid, 0);
    checkOutput("reset rsp0_result", rsp0_result, 0);
    checkOutput("reset rsp0_zero", rsp0_zero, 0);
    checkOutput("reset rsp1_err", rsp1_err, 0);
    checkOutput("reset alu_ctrl", alu_ctrl, 0);
    checkOutput("reset alu_a", alu_a, 0);
    idleInputs();
    rst = 0;
  endtask

  task automatic setReq(input logic who, input logic valid, input logic [3:0] ctrl,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (who) begin
      req1_valid = valid; req1_ctrl = ctrl; req1_a = a; req1_b = b;
    end else begin
      req0_valid = valid; req0_ctrl = ctrl; req0_a = a; req0_b = b;
    end
  endtask

  // One full transaction: grant, issue cycle, visible response, consumption.
  task automatic applyStimulus(input vec_t v);
    rsp0_ready = 1;
    rsp1_ready = 1;
    setReq(v.who, 1, v.ctrl, v.a, v.b);
    #1;
    checkOutput("grant ready", v.who ? req1_ready : req0_ready, 1);
    checkOutput("grant other ready", v.who ? req0_ready : req1_ready, 0);
    nextCycle();
    setReq(v.who, 0, 4'd1, ~v.a, ~v.b);
    #1;
    checkOutput("issue alu_ctrl", alu_ctrl, v.expErr ? 4'd0 : v.ctrl);
    checkOutput("issue alu_a", alu_a, v.expErr ? 32'd0 : v.a);
    checkOutput("issue alu_b", alu_b, v.expErr ? 32'd0 : v.b);
    nextCycle();
    #1;
    checkOutput("rsp valid", v.who ? rsp1_valid : rsp0_valid, 1);
    checkOutput("rsp result", v.who ? rsp1_result : rsp0_result, v.expResult);
    checkOutput("rsp zero", v.who ? rsp1_zero : rsp0_zero, v.expZero);
    checkOutput("rsp err", v.who ? rsp1_err : rsp0_err, v.expErr);
    checkOutput("idle alu_ctrl", alu_ctrl, 0);
    nextCycle();
    #1;
    checkOutput("rsp consumed", v.who ? rsp1_valid : rsp0_valid, 0);
  endtask

  initial begin
    logic [5:0] expR0, expR1, expV0, expV1;
    logic [8:0] bpR0, bpR1, bpV1;

    vecs[0]  = '{0, ADD,   32'd5,         32'd7,      32'd12,        0, 0};
    vecs[1]  = '{1, SUB,   32'd3,         32'd5,      32'hFFFF_FFFE, 0, 0};
    vecs[2]  = '{0, SLL,   32'd1,         32'd4,      32'd16,        0, 0};
    vecs[3]  = '{1, SLT,   32'hFFFF_FFFF, 32'd3,      32'd1,         0, 0};
    vecs[4]  = '{0, SLTU,  32'hFFFF_FFFF, 32'd3,      32'd0,         1, 0};
    vecs[5]  = '{1, XOR,   32'h0000_F0F0, 32'h0F0F,   32'h0000_FFFF, 0, 0};
    vecs[6]  = '{0, SRL,   32'h8000_0000, 32'd4,      32'h0800_0000, 0, 0};
    vecs[7]  = '{1, SRA,   32'h8000_0000, 32'd4,      32'hF800_0000, 0, 0};
    vecs[8]  = '{0, OR,    32'h0000_00F0, 32'h0F,     32'h0000_00FF, 0, 0};
    vecs[9]  = '{1, AND,   32'h0000_00F0, 32'h3C,     32'h0000_0030, 0, 0};
    vecs[10] = '{0, 4'd12, 32'd3,         32'd4,      32'd0,         1, 1};
    vecs[11] = '{1, 4'd15, 32'd9,         32'd9,      32'd0,         1, 1};

    rst = 1;
    idleInputs();
    @(negedge clk);
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Both requesters hammering with both responses consumed: grant, grant, gap.
    doReset();
    expR0 = 6'b001001; expR1 = 6'b010010; expV0 = 6'b100100; expV1 = 6'b001000;
    setReq(0, 1, SUB, 32'd9, 32'd9);
    setReq(1, 1, XOR, 32'd3, 32'd3);
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("contend c%0d req0_ready", c), req0_ready, expR0[c]);
      checkOutput($sformatf("contend c%0d req1_ready", c), req1_ready, expR1[c]);
      checkOutput($sformatf("contend c%0d rsp0_valid", c), rsp0_valid, expV0[c]);
      checkOutput($sformatf("contend c%0d rsp1_valid", c), rsp1_valid, expV1[c]);
      if (c == 2) begin
        checkOutput("contend rsp0_result", rsp0_result, 0);
        checkOutput("contend rsp0_zero", rsp0_zero, 1);
      end
      if (c == 3) begin
        checkOutput("contend rsp1_result", rsp1_result, 0);
        checkOutput("contend rsp1_zero", rsp1_zero, 1);
      end
      nextCycle();
    end

    // req1 withholds rsp1_ready: its slot freezes and req0 keeps cycling alone.
    doReset();
    bpR0 = 9'b001001001; bpR1 = 9'b000000010; bpV1 = 9'b111111000;
    rsp1_ready = 0;
    setReq(0, 1, ADD, 32'd1, 32'd1);
    setReq(1, 1, XOR, 32'd6, 32'd3);
    for (int c = 0; c < 9; c++) begin
      #1;
      checkOutput($sformatf("bp c%0d req0_ready", c), req0_ready, bpR0[c]);
      checkOutput($sformatf("bp c%0d req1_ready", c), req1_ready, bpR1[c]);
      checkOutput($sformatf("bp c%0d rsp1_valid", c), rsp1_valid, bpV1[c]);
      if (c >= 3) checkOutput($sformatf("bp c%0d rsp1_result", c), rsp1_result, 32'd5);
      nextCycle();
    end
    setReq(0, 0, ADD, 0, 0);
    setReq(1, 0, ADD, 0, 0);
    rsp1_ready = 1;
    nextCycle();
    #1;
    checkOutput("bp rsp1 released", rsp1_valid, 0);

    // Contention after req0 was last served: round-robin hands the slot to req1.
    doReset();
    setReq(0, 1, ADD, 32'd2, 32'd2);
    #1;
    checkOutput("rr solo req0_ready", req0_ready, 1);
    nextCycle();
    setReq(0, 0, ADD, 0, 0);
    nextCycle();
    nextCycle();
    setReq(0, 1, ADD, 32'd1, 32'd2);
    setReq(1, 1, ADD, 32'd3, 32'd4);
    #1;
    checkOutput("rr contend req0_ready", req0_ready, FIXED ? 1'b1 : 1'b0);
    checkOutput("rr contend req1_ready", req1_ready, FIXED ? 1'b0 : 1'b1);
    nextCycle();
    #1;
    checkOutput("rr follow req0_ready", req0_ready, FIXED ? 1'b0 : 1'b1);
    checkOutput("rr follow req1_ready", req1_ready, FIXED ? 1'b1 : 1'b0);
    nextCycle();
    setReq(0, 0, ADD, 0, 0);
    setReq(1, 0, ADD, 0, 0);
    nextCycle();

    // Reset one cycle after a grant discards the in-flight operation.
    doReset();
    rsp0_ready = 0;
    setReq(0, 1, ADD, 32'd5, 32'd7);
    #1;
    checkOutput("rstmid req0_ready", req0_ready, 1);
    nextCycle();
    setReq(0, 0, ADD, 0, 0);
    setReq(1, 1, ADD, 32'd1, 32'd1);
    rst = 1;
    #1;
    checkOutput("rstmid alu_a", alu_a, 32'd5);
    checkOutput("rstmid req1_ready", req1_ready, 0);
    nextCycle();
    rst = 0;
    setReq(1, 0, ADD, 0, 0);
    #1;
    checkOutput("rstmid after rsp0_valid", rsp0_valid, 0);
    checkOutput("rstmid after rsp1_valid", rsp1_valid, 0);
    checkOutput("rstmid after alu_a", alu_a, 0);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      #1;
      checkOutput($sformatf("rstmid late%0d rsp0_valid", c), rsp0_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
